// File: rtl/palu_result_buffer.sv
// ---------------------------------------------------------------------------
// palu_result_buffer
//
// This stage sits after the 4-bit ALU. Each ALU result is written into a small
// first-word-fall-through FIFO, together with its carry, its op selector and a
// zero flag. The display/register-write stage then reads the entries back in
// the order they were written.
//
// Parameters:
//   DEPTH  - number of FIFO entries (power of two, >= 2)
//   DATA_W - ALU result width
//   CNT_W  - occupancy count width, log2(DEPTH)+1
//
// Ports:
//   clk, rst_n          - rising-edge clock, async active-low reset
//   flush               - synchronous clear of every entry; wins over push/pop
//   in_valid/in_ready   - producer handshake (in_ready = not full)
//   result_in, carry_in,
//   op_in               - ALU result, carry and selector to store
//   out_valid/out_ready - consumer handshake (out_valid = not empty)
//   out_result, out_carry,
//   out_zero, out_op    - head entry fields; all read 0 while the FIFO is empty
//   count               - current occupancy, 0..DEPTH
//   carry_events        - only when PALU_BUF_STATS_EN is defined: saturating
//                         count of accepted pushes that had carry_in=1
//
// Optional feature macro: PALU_BUF_STATS_EN
// ---------------------------------------------------------------------------
module palu_result_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] result_in,
  input  logic              carry_in,
  input  logic [1:0]        op_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_carry,
  output logic              out_zero,
  output logic [1:0]        out_op,
`ifdef PALU_BUF_STATS_EN
  output logic [7:0]        carry_events,
`endif
  output logic [CNT_W-1:0]  count
);

  // DEPTH is a power of two, so the pointers simply wrap when they overflow.
  localparam int PTR_W = CNT_W - 1;

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic [DATA_W-1:0] mem_result [DEPTH];
  logic              mem_carry  [DEPTH];
  logic              mem_zero   [DEPTH];
  logic [1:0]        mem_op     [DEPTH];

  logic push;
  logic pop;

  // The handshake depends only on the registered occupancy. Because of that,
  // in_ready never looks at out_ready, and there is no combinational path
  // from the input side to the output side.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // The head entry falls through to the outputs. Its fields are forced to 0
  // while the FIFO is empty, so the consumer never sees stale storage.
  assign out_result = out_valid ? mem_result[rd_ptr] : '0;
  assign out_carry  = out_valid ? mem_carry[rd_ptr]  : 1'b0;
  assign out_zero   = out_valid ? mem_zero[rd_ptr]   : 1'b0;
  assign out_op     = out_valid ? mem_op[rd_ptr]     : 2'b00;

  // Entry storage has no reset. An entry only becomes visible after the
  // count covers it. The zero flag is captured here once, at push time.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_result[wr_ptr] <= result_in;
      mem_carry[wr_ptr]  <= carry_in;
      mem_zero[wr_ptr]   <= (result_in == '0);
      mem_op[wr_ptr]     <= op_in;
    end
  end

  // Pointer and occupancy bookkeeping. A flush drops any push or pop on the
  // same edge. A push and a pop together leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef PALU_BUF_STATS_EN
  // Counts accepted pushes that carried out. The counter holds at 255.
  // A flush clears it, and a push on the flush edge is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_events <= 8'd0;
    end else if (flush) begin
      carry_events <= 8'd0;
    end else if (push && carry_in && (carry_events != 8'hFF)) begin
      carry_events <= carry_events + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_palu_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_palu_result_buffer
//
// Directed-vector bench for palu_result_buffer. A queue-based reference model
// follows the FIFO contents. A compare process checks every DUT output
// against that model on each falling edge. Literal expectations at key points
// pin the model itself.
// Optional feature macro: PALU_BUF_STATS_EN
// ---------------------------------------------------------------------------
module tb_palu_result_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] result_in;
  logic              carry_in;
  logic [1:0]        op_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_carry;
  logic              out_zero;
  logic [1:0]        out_op;
  logic [CNT_W-1:0]  count;
`ifdef PALU_BUF_STATS_EN
  logic [7:0]        carry_events;
`endif

  int checks   = 0;
  int failures = 0;

  palu_result_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .result_in  (result_in),
    .carry_in   (carry_in),
    .op_in      (op_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_op     (out_op),
`ifdef PALU_BUF_STATS_EN
    .carry_events (carry_events),
`endif
    .count      (count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of what the consumer should see, in order
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carry;
    logic [1:0]        op;
  } entry_t;

  entry_t model_q[$];
  int     model_carry_events;

  // Model update on each rising edge. A flush or reset empties the queue.
  // Otherwise accept/release depend on the occupancy before the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
      model_carry_events <= 0;
    end else if (flush) begin
      model_q.delete();
      model_carry_events <= 0;
    end else begin
      automatic bit do_push = in_valid && (model_q.size() < DEPTH);
      automatic bit do_pop  = out_ready && (model_q.size() > 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        automatic entry_t e;
        e.result = result_in;
        e.carry  = carry_in;
        e.op     = op_in;
        model_q.push_back(e);
        if (carry_in && model_carry_events < 255)
          model_carry_events <= model_carry_events + 1;
      end
    end
  end

  // Single comparison point shared by the model compare and literal checks
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge outside reset, check all outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      automatic int n = model_q.size();
      checkOutput("m_count",     int'(count),     n);
      checkOutput("m_in_ready",  int'(in_ready),  (n < DEPTH) ? 1 : 0);
      checkOutput("m_out_valid", int'(out_valid), (n > 0) ? 1 : 0);
      if (n > 0) begin
        checkOutput("m_out_result", int'(out_result), int'(model_q[0].result));
        checkOutput("m_out_carry",  int'(out_carry),  int'(model_q[0].carry));
        checkOutput("m_out_zero",   int'(out_zero),   (model_q[0].result == 0) ? 1 : 0);
        checkOutput("m_out_op",     int'(out_op),     int'(model_q[0].op));
      end else begin
        checkOutput("m_idle_fields",
                    int'({out_result, out_carry, out_zero, out_op}), 0);
      end
`ifdef PALU_BUF_STATS_EN
      checkOutput("m_carry_events", int'(carry_events), model_carry_events);
`endif
    end
  end

  // Drive one cycle of inputs. The task returns 1 ns after the rising edge,
  // so the caller then sees that edge's result.
  task automatic applyStimulus(input logic iv, input logic [3:0] r, input logic c,
                               input logic [1:0] op, input logic ordy, input logic fl);
    in_valid  = iv;
    result_in = r;
    carry_in  = c;
    op_in     = op;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drainAll();
    int guard;
    guard = 0;
    while (count != 0 && guard < 20) begin
      applyStimulus(1'b0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0);
      guard++;
    end
    checkOutput("drain_done", int'(count), 0);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] v;
    rst_n = 1'b0;
    in_valid = 1'b0; result_in = '0; carry_in = 1'b0; op_in = 2'b00;
    out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_count",     int'(count),      0);
    checkOutput("rst_out_valid", int'(out_valid),  0);
    checkOutput("rst_in_ready",  int'(in_ready),   1);
    checkOutput("rst_out_result", int'(out_result), 0);
    rst_n = 1'b1;

    // Single push A / carry 1 / op 01
    applyStimulus(1'b1, 4'hA, 1'b1, 2'b01, 1'b0, 1'b0);
    checkOutput("p1_out_valid", int'(out_valid),  1);
    checkOutput("p1_out_result", int'(out_result), 10);
    checkOutput("p1_out_carry", int'(out_carry),  1);
    checkOutput("p1_out_zero",  int'(out_zero),   0);
    checkOutput("p1_out_op",    int'(out_op),     1);
    checkOutput("p1_count",     int'(count),      1);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("p1_popped", int'(out_valid), 0);

    // Zero tag
    applyStimulus(1'b1, 4'h0, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("z_out_zero",  int'(out_zero),  1);
    checkOutput("z_out_carry", int'(out_carry), 1);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0);

    // Fill 1..4, then an ignored fifth push of 5
    for (int i = 1; i <= 4; i++) begin
      v = 4'(i);
      applyStimulus(1'b1, v, 1'b0, v[1:0], 1'b0, 1'b0);
    end
    checkOutput("full_count",    int'(count),    4);
    checkOutput("full_in_ready", int'(in_ready), 0);
    applyStimulus(1'b1, 4'h5, 1'b0, 2'b01, 1'b0, 1'b0);
    checkOutput("full_ignore_count", int'(count), 4);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain_order", int'(out_result), i);
      applyStimulus(1'b0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", int'(out_valid), 0);

    // Push and pop together at count 2, then mixed ops that wrap the pointers
    applyStimulus(1'b1, 4'h1, 1'b0, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b1, 2'b11, 1'b1, 1'b0);
    checkOutput("pp_count", int'(count), 2);
    for (int i = 0; i < 10; i++) begin
      v = 4'(i + 4);
      applyStimulus((i != 3 && i != 7), v, v[0], v[1:0], (i % 4 != 1), 1'b0);
    end
    checkOutput("mix_count",  int'(count),      3);
    checkOutput("mix_head",   int'(out_result), 10);
    drainAll();

    // Flush together with a push of 7 at count 3
    for (int i = 1; i <= 3; i++) begin
      v = 4'(i);
      applyStimulus(1'b1, v, 1'b0, 2'b10, 1'b0, 1'b0);
    end
    checkOutput("fl_pre_count", int'(count), 3);
    applyStimulus(1'b1, 4'h7, 1'b1, 2'b11, 1'b0, 1'b1);
    checkOutput("fl_count",     int'(count),     0);
    checkOutput("fl_out_valid", int'(out_valid), 0);
    checkOutput("fl_in_ready",  int'(in_ready),  1);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("fl_7_dropped", int'(out_valid), 0);

    // Asynchronous reset in the middle of a cycle at count 3
    for (int i = 1; i <= 3; i++) begin
      v = 4'(i + 8);
      applyStimulus(1'b1, v, 1'b1, 2'b01, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("ar_pre_count", int'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_count",     int'(count),     0);
    checkOutput("ar_out_valid", int'(out_valid), 0);
    checkOutput("ar_in_ready",  int'(in_ready),  1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef PALU_BUF_STATS_EN
    // 300 carry pushes while the consumer keeps popping: the counter saturates
    checkOutput("st_start", int'(carry_events), 0);
    for (int i = 0; i < 300; i++) begin
      v = 4'(i);
      applyStimulus(1'b1, v, 1'b1, v[1:0], 1'b1, 1'b0);
    end
    checkOutput("st_saturate", int'(carry_events), 255);
    applyStimulus(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("st_flush", int'(carry_events), 0);
`endif

    applyStimulus(1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
